// File: rtl/piso_shift_register_array.sv
// Parallel-in, serial-out lane array: one load of BIT_WIDTH DEPTH-bit words, shifted out MSB-first.
// Optional macro PISO_SHIFT_REGISTER_ARRAY_BACK_TO_BACK_EN accepts a new load on the last beat's handshake.
module piso_shift_register_array #(
    parameter int unsigned BIT_WIDTH = 8,
    parameter int unsigned DEPTH     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [BIT_WIDTH*DEPTH-1:0] load_data,
    input  logic                       load_valid,
    output logic                       load_ready,
    output logic [BIT_WIDTH-1:0]       out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       busy
);
    localparam int unsigned CW = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CW-1:0]    r_count;
    logic [DEPTH-1:0] r_lanes [BIT_WIDTH];
    logic             w_handshake;
    logic             w_load;

    assign w_handshake = out_valid && out_ready;
    assign w_load      = load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_load) w_next_state = SHIFT;
            SHIFT:   if (w_handshake && out_last && !w_load) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (r_state == SHIFT);
        busy      = (r_state == SHIFT);
        out_last  = (r_state == SHIFT) && (r_count == LAST);
`ifdef PISO_SHIFT_REGISTER_ARRAY_BACK_TO_BACK_EN
        load_ready = (r_state == IDLE) || (out_last && out_ready);
`else
        load_ready = (r_state == IDLE);
`endif
        out = '0;
        for (int unsigned i = 0; i < BIT_WIDTH; i++) begin
            out[i] = (r_state == SHIFT) && r_lanes[i][DEPTH-1];
        end
    end

    // A load takes priority over the shift so a back-to-back load replaces the drained lanes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            for (int unsigned i = 0; i < BIT_WIDTH; i++) begin
                r_lanes[i] <= '0;
            end
        end else if (w_load) begin
            r_count <= '0;
            for (int unsigned i = 0; i < BIT_WIDTH; i++) begin
                r_lanes[i] <= load_data[i*DEPTH +: DEPTH];
            end
        end else if (w_handshake) begin
            r_count <= out_last ? '0 : r_count + 1'b1;
            for (int unsigned i = 0; i < BIT_WIDTH; i++) begin
                r_lanes[i] <= {r_lanes[i][DEPTH-2:0], 1'b0};
            end
        end
    end
endmodule

// File: tb/tb_piso_shift_register_array.sv
// Self-checking bench for piso_shift_register_array (BIT_WIDTH=8, DEPTH=8).
module tb_piso_shift_register_array;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] load_data;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  out;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    piso_shift_register_array #(.BIT_WIDTH(8), .DEPTH(8)) dut (
        .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]     data;
        logic [7:0][7:0] beats;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Beat k carries bit (7-k) of every lane word.
    function automatic logic [7:0] beat_of(input logic [63:0] d, input int k);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[i*8 + 7 - k];
        return r;
    endfunction

    task automatic do_load(input logic [63:0] d);
        int t = 0;
        while (!load_ready && t < 50) begin
            tick();
            t++;
        end
        chk("load_wait_timeout", t >= 50, 0);
        load_data  = d;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic unload_check(input logic [7:0][7:0] exp_beats);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("beat_valid", out_valid, 1);
            chk("beat_busy", busy, 1);
            chk("beat_data", out, exp_beats[k]);
            chk("beat_last", out_last, (k == 7));
            tick();
        end
        chk("end_valid", out_valid, 0);
        chk("end_ready", load_ready, 1);
        chk("end_out", out, 0);
        chk("end_busy", busy, 0);
    endtask

    initial begin
        logic [63:0] d;
        logic [7:0]  recon [8];
        logic [7:0]  w [8];
        int nb, cyc, nacc;
        logic accept;
        logic [7:0] ev [18];
        logic [7:0] eo [18];
        logic [7:0] el [18];
        logic [7:0] rv [18];
        logic [7:0] ro [18];
        logic [7:0] rl [18];

        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[1] = '{64'h0, 64'h0};
        vecs[2] = '{64'h0102_0408_1020_4080, 64'h8040_2010_0804_0201};
        vecs[3] = '{64'hA5A5_A5A5_A5A5_A5A5, 64'hFF00_FF00_00FF_00FF};
        vecs[4] = '{64'h8040_2010_0804_0201, 64'h0102_0408_1020_4080};

        reset = 1'b1; load_data = '0; load_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_load_ready", load_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);

        for (int v = 0; v < 5; v++) begin
            do_load(vecs[v].data);
            unload_check(vecs[v].beats);
        end

        // Basic unload with reconstruction by a left shift register model.
        for (int i = 0; i < 8; i++) begin
            w[i] = 8'hA5 ^ 8'(i);
            d[i*8 +: 8] = w[i];
            recon[i] = '0;
        end
        do_load(d);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("basic_valid", out_valid, 1);
            chk("basic_beat", out, beat_of(d, k));
            chk("basic_last", out_last, (k == 7));
            for (int i = 0; i < 8; i++) recon[i] = {recon[i][6:0], out[i]};
            tick();
        end
        chk("basic_idle", out_valid, 0);
        for (int i = 0; i < 8; i++) chk("basic_recon", recon[i], w[i]);

        // Random backpressure with ignored load_valid pulses.
        for (int r = 0; r < 20; r++) begin
            d = {$urandom, $urandom};
            do_load(d);
            nb = 0; cyc = 0;
            while (nb < 8 && cyc < 200) begin
                out_ready = 1'($urandom_range(0, 1));
                load_valid = ($urandom_range(0, 3) == 0) && !(nb == 7 && out_ready);
                load_data = {$urandom, $urandom};
                #1;
                chk("bp_valid", out_valid, 1);
                chk("bp_beat", out, beat_of(d, nb));
                chk("bp_last", out_last, (nb == 7));
`ifdef PISO_SHIFT_REGISTER_ARRAY_BACK_TO_BACK_EN
                chk("bp_load_ready", load_ready, (nb == 7) && out_ready);
`else
                chk("bp_load_ready", load_ready, 0);
`endif
                if (out_ready) nb++;
                tick();
                cyc++;
            end
            load_valid = 1'b0;
            chk("bp_beat_count", nb, 8);
            chk("bp_idle", out_valid, 0);
        end

        // Reset mid-transfer; reset dominates load_valid and out_ready.
        do_load(vecs[3].data);
        out_ready = 1'b1;
        repeat (4) tick();
        reset = 1'b1; load_valid = 1'b1; load_data = '1;
        tick();
        reset = 1'b0; load_valid = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_out", out, 0);
        chk("mid_rst_ready", load_ready, 1);
        chk("mid_rst_last", out_last, 0);
        tick();
        chk("mid_rst_stay_idle", out_valid, 0);
        do_load(vecs[2].data);
        unload_check(vecs[2].beats);

        // Back-to-back loads: all-ones then all-zeros.
        for (int c = 0; c < 18; c++) begin
            ev[c] = 0; eo[c] = 0; el[c] = 0;
        end
`ifdef PISO_SHIFT_REGISTER_ARRAY_BACK_TO_BACK_EN
        for (int c = 0; c < 16; c++) begin
            ev[c] = 1; eo[c] = (c < 8) ? 8'hFF : 8'h00; el[c] = (c == 7 || c == 15);
        end
`else
        for (int c = 0; c < 8; c++) begin
            ev[c] = 1; eo[c] = 8'hFF; el[c] = (c == 7);
        end
        for (int c = 9; c < 17; c++) begin
            ev[c] = 1; eo[c] = 8'h00; el[c] = (c == 16);
        end
`endif
        out_ready = 1'b1;
        load_data = '1;
        load_valid = 1'b1;
        nacc = 0;
        for (int c = 0; c < 18; c++) begin
            accept = load_valid && load_ready;
            tick();
            if (accept) begin
                nacc++;
                if (nacc == 1) load_data = '0;
                if (nacc == 2) load_valid = 1'b0;
            end
            rv[c] = 8'(out_valid); ro[c] = out; rl[c] = 8'(out_last);
        end
        load_valid = 1'b0;
        for (int c = 0; c < 18; c++) begin
            chk("b2b_valid", rv[c], ev[c]);
            chk("b2b_out", ro[c], eo[c]);
            chk("b2b_last", rl[c], el[c]);
        end
        chk("b2b_loads", nacc, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/piso_shift_register_array.md
# piso_shift_register_array

Parallel-in, serial-out counterpart of the left shift register array. It accepts one parallel load of BIT_WIDTH lanes, each a DEPTH-bit word, then shifts all lanes out MSB-first, one BIT_WIDTH-wide beat per handshake. Its beat stream feeds a left shift register array, which reconstructs the loaded words after DEPTH beats. It sits between a parallel producer and a bit-serial link, with valid/ready on both sides.

## Interface
- BIT_WIDTH, 8, number of lanes; also the output beat width
- DEPTH, 8, bits per lane and beats per load (≥ 2)

- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- load_data  input  BIT_WIDTH*DEPTH  lane i word = load_data[i*DEPTH +: DEPTH]
- load_valid  input  1  load_data is valid
- load_ready  output  1  block can accept a load
- out  output  BIT_WIDTH  current beat; bit i = current MSB of lane i
- out_valid  output  1  out holds a valid beat
- out_ready  input  1  consumer accepts the beat
- out_last  output  1  current beat is beat DEPTH-1 of the load
- busy  output  1  a load is in progress (state SHIFT)

## Operation
- Storage: BIT_WIDTH registers, each DEPTH bits. Beat counter: clog2(DEPTH) bits, range 0..DEPTH-1.
- States: IDLE, SHIFT.
- IDLE: load_ready=1, out_valid=0, busy=0. If load_valid, capture all lanes, clear the counter, and go to SHIFT.
- SHIFT: load_ready=0 (except under the macro), out_valid=1, busy=1. out[i] = lane_reg[i][DEPTH-1]. out_last = (count == DEPTH-1).
- On an out handshake (out_valid && out_ready): every lane shifts left by one, 0 enters at bit 0, and count increments.
- On a handshake with out_last=1: go to IDLE and clear count. Lane registers are then all zero.
- Without a handshake, out, out_last and all state hold. Stall length is unbounded.
- out is a function of registers only; there is no combinational path from inputs to out.
- out_valid is never withdrawn once asserted until the last beat is consumed.
- out is 0 whenever out_valid=0.
- reset: state IDLE, count 0, lane registers 0. A transfer in progress is abandoned, with no further beats and out_last never asserted. reset dominates load_valid and out_ready in the same cycle.

## Timing
- Reset values: load_ready=1, out_valid=0, out=0, out_last=0, busy=0. The first load can be accepted on the cycle after reset deasserts.
- Load accepted at edge N: out_valid=1 and the first beat is on out from cycle N+1.
- Per load: exactly DEPTH beats. Minimum DEPTH cycles with out_ready held high.
- Without the macro: one idle cycle (load_ready=1, out_valid=0) between loads. Throughput is DEPTH beats per DEPTH+1 cycles.
- load_valid in SHIFT is ignored. The producer holds load_data/load_valid until load_ready.

## Configuration
- PISO_SHIFT_REGISTER_ARRAY_BACK_TO_BACK_EN
- Defined:
  - load_ready is also high in SHIFT when out_last && out_ready.
  - A load accepted in that cycle is captured in the same edge as the last beat.
  - The block stays in SHIFT with count 0, and out_valid stays high with no gap. Throughput is 1 beat/cycle.
  - load_ready then depends combinationally on out_ready.
- Undefined: load_ready = (state == IDLE), registered-only; behaviour as in Operation.

## Test plan
- Reset/idle: assert reset 2 cycles, then release → load_ready=1, out_valid=0, out=0, out_last=0, busy=0.
- Basic unload: BIT_WIDTH=8, DEPTH=8, lane i word = 8'hA5 ^ i, out_ready=1.
  - out_valid rises 1 cycle after the load.
  - Beat k has bit i = word_i[7-k].
  - out_last only on beat 7; back in IDLE the next cycle.
  - A model left shift register array fed with out reproduces every word.
- Backpressure: toggle out_ready pseudo-randomly.
  - out is stable while stalled; the beat sequence matches the basic case.
  - Exactly 8 beats; load_valid pulses during SHIFT are ignored.
- Reset mid-transfer: reset after beat 3 → next cycle out_valid=0, out=0, load_ready=1. A new load then starts from its beat 0.
- Back-to-back: two loads 8'hFF / 8'h00 on all lanes.
  - Macro undefined: one gap cycle between beat 7 and the next beat 0.
  - Macro defined: 16 consecutive valid beats, with out_last on beats 7 and 15.
